// File: rtl/fp32_to_int_if.sv
// Operand/result handshake bundle for the fp32 -> int32 converter.
// The master drives operands and accepts results; the slave is the converter.
interface fp32_to_int_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_int;
    logic        out_invalid;
    logic        out_inexact;

    modport master (
        output in_valid, in_a, out_ready,
        input  in_ready, out_valid, out_int, out_invalid, out_inexact
    );

    modport slave (
        input  in_valid, in_a, out_ready,
        output in_ready, out_valid, out_int, out_invalid, out_inexact
    );
endinterface

// File: rtl/fp32_to_int_conv.sv
// Multi-cycle fp32 -> signed int32 converter, round-toward-zero, saturating.
// Mantissa alignment is iterative, at most SHIFT_STEP bit positions per cycle.
module fp32_to_int_conv #(
    parameter int unsigned SHIFT_STEP = 4
) (
    input logic          clk,
    input logic          rst_n,
    fp32_to_int_if.slave bus
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REM_W  = 5;
    localparam int unsigned EXP_W  = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLASSIFY = 2'd1,
        SHIFT    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   mag_q, mag_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic                left_q, left_d;
    logic [DATA_W-1:0]   out_int_q, out_int_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                invalid_q, invalid_d;
    logic                inexact_q, inexact_d;

    logic                     sign;
    logic [7:0]               exp_f;
    logic [22:0]              mant;
    logic signed [EXP_W-1:0]  e_unb;
    logic [DATA_W-1:0]        sat_val;
    logic [REM_W-1:0]         step_k;
    logic [DATA_W-1:0]        lost_mask;

    assign sign    = a_q[31];
    assign exp_f   = a_q[30:23];
    assign mant    = a_q[22:0];
    assign e_unb   = $signed({2'b00, exp_f}) - $signed(EXP_W'(127));
    assign sat_val = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    assign step_k  = (rem_q > REM_W'(SHIFT_STEP)) ? REM_W'(SHIFT_STEP) : rem_q;
    // Bits that fall off the bottom of mag during a right shift of step_k.
    assign lost_mask = ~(32'hFFFF_FFFF << step_k);

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            mag_q       <= '0;
            rem_q       <= '0;
            left_q      <= 1'b0;
            out_int_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            invalid_q   <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            mag_q       <= mag_d;
            rem_q       <= rem_d;
            left_q      <= left_d;
            out_int_q   <= out_int_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            invalid_q   <= invalid_d;
            inexact_q   <= inexact_d;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        mag_d       = mag_q;
        rem_d       = rem_q;
        left_d      = left_q;
        out_int_d   = out_int_q;
        out_valid_d = out_valid_q;
        invalid_d   = invalid_q;
        inexact_d   = inexact_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d       = bus.in_a;
                    invalid_d = 1'b0;
                    inexact_d = 1'b0;
                    state_d   = CLASSIFY;
                end
            end

            CLASSIFY: begin
                state_d = DONE;
                if (exp_f == 8'hFF) begin
                    out_int_d = (mant != 23'd0) ? 32'h7FFF_FFFF : sat_val;
                    invalid_d = 1'b1;
                end else if (exp_f == 8'h00) begin
                    out_int_d = '0;
                    inexact_d = (mant != 23'd0);
                end else if (e_unb < 0) begin
                    out_int_d = '0;
                    inexact_d = 1'b1;
                end else if (a_q == 32'hCF00_0000) begin
                    out_int_d = 32'h8000_0000;
                end else if (e_unb >= 31) begin
                    out_int_d = sat_val;
                    invalid_d = 1'b1;
                end else begin
                    mag_d = {8'b0, 1'b1, mant};
                    if (e_unb >= 23) begin
                        left_d = 1'b1;
                        rem_d  = REM_W'(e_unb - EXP_W'(23));
                    end else begin
                        left_d = 1'b0;
                        rem_d  = REM_W'(EXP_W'(23) - e_unb);
                    end
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (rem_q != '0) begin
                    if (left_q) begin
                        mag_d = mag_q << step_k;
                    end else begin
                        mag_d     = mag_q >> step_k;
                        inexact_d = inexact_q | ((mag_q & lost_mask) != '0);
                    end
                    rem_d = rem_q - step_k;
                end else begin
                    out_int_d = sign ? (~mag_q + 32'd1) : mag_q;
                    state_d   = DONE;
                end
            end

            DONE: begin
                // out_valid rises one cycle after entering DONE, then holds for the handshake.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    invalid_d   = 1'b0;
                    inexact_d   = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_int     = out_int_q;
    assign bus.out_invalid = invalid_q;
    assign bus.out_inexact = inexact_q;

endmodule

// File: tb/tb_fp32_to_int_conv.sv
// Directed, table-driven bench for fp32_to_int_conv (SHIFT_STEP = 4),
// plus hand-written backpressure and mid-conversion reset sequences.
module tb_fp32_to_int_conv;

    logic clk;
    logic rst_n;

    fp32_to_int_if bus ();

    fp32_to_int_conv #(.SHIFT_STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] exp_int;
        logic        exp_inv;
        logic        exp_inex;
        int          exp_lat;   // 0: latency not checked
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Present one operand, wait for the result, complete the handshake.
    task automatic convert(input logic [31:0] a, output logic [31:0] res,
                           output logic inv, output logic inex, output int lat);
        int guard;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) begin
            failures++;
            checks++;
            $display("FAIL timeout: no out_valid for operand 0x%08h", a);
        end
        res  = bus.out_int;
        inv  = bus.out_invalid;
        inex = bus.out_inexact;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("flags_cleared", 32'({bus.out_invalid, bus.out_inexact}), 32'd0);
    endtask

    vec_t        vecs[$];
    logic [31:0] res;
    logic        inv, inex;
    int          lat;
    logic [31:0] held_int;
    logic        held_inv, held_inex;
    int          guard;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        vecs.push_back('{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 9});
        vecs.push_back('{32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b1, 9});
        vecs.push_back('{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 2});
        vecs.push_back('{32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 0});
        vecs.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 5});
        vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2});
        vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2});
        vecs.push_back('{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2});
        vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2});
        vecs.push_back('{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2});
        vecs.push_back('{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 2});
        vecs.push_back('{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 2});
        vecs.push_back('{32'h42F6_0000, 32'h0000_007B, 1'b0, 1'b0, 8});
        vecs.push_back('{32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, 8});
        vecs.push_back('{32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 9});
        vecs.push_back('{32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 9});
        vecs.push_back('{32'hCF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2});

        #23;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_int", bus.out_int, 32'd0);
        chk("rst_flags", 32'({bus.out_invalid, bus.out_inexact}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            convert(vecs[i].a, res, inv, inex, lat);
            chk($sformatf("int[%08h]", vecs[i].a), res, vecs[i].exp_int);
            chk($sformatf("invalid[%08h]", vecs[i].a), 32'(inv), 32'(vecs[i].exp_inv));
            chk($sformatf("inexact[%08h]", vecs[i].a), 32'(inex), 32'(vecs[i].exp_inex));
            if (vecs[i].exp_lat != 0)
                chk($sformatf("latency[%08h]", vecs[i].a), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Backpressure: result of -3.14159 held for 10 cycles while a new operand is offered.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'hC049_0FDB;
        @(posedge clk);
        #1;
        bus.in_a = 32'h3F80_0000;
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("bp_valid_seen", 32'(bus.out_valid), 32'd1);
        held_int  = bus.out_int;
        held_inv  = bus.out_invalid;
        held_inex = bus.out_inexact;
        chk("bp_int", held_int, 32'hFFFF_FFFD);
        chk("bp_flags", 32'({held_inv, held_inex}), 32'b01);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_int", bus.out_int, 32'hFFFF_FFFD);
            chk("bp_hold_flags", 32'({bus.out_invalid, bus.out_inexact}), 32'b01);
            chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        convert(32'h42F6_0000, res, inv, inex, lat);
        chk("bp_next_int", res, 32'h0000_007B);
        chk("bp_next_flags", 32'({inv, inex}), 32'd0);

        // Reset in the middle of converting 1.0.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h3F80_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            chk("rst_no_stale_valid", 32'(bus.out_valid), 32'd0);
        end
        convert(32'h42F6_0000, res, inv, inex, lat);
        chk("rst_after_int", res, 32'h0000_007B);
        chk("rst_after_flags", 32'({inv, inex}), 32'd0);
        chk("rst_after_latency", 32'(lat), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
